// File: rtl/router_pkg.sv
// Shared types and sizing helpers for the multi-lane weight router and its lane buffers.
package router_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_STREAM,
        ST_DONE
    } state_t;

    // Weights carried by one scratchpad row.
    function automatic int elems_of(input int spad_w, input int data_w);
        return spad_w / data_w;
    endfunction

    function automatic int row_idx_w(input int depth, input int elems);
        return (depth / elems > 1) ? $clog2(depth / elems) : 1;
    endfunction

    function automatic int elem_idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/spad.sv
// Weight scratchpad: one synchronous write port, one read port with one cycle of latency.
module spad #(
    parameter int SPAD_DATA_WIDTH = 64,
    parameter int ADDR_WIDTH      = 8
) (
    input  logic                       i_clk,
    input  logic                       i_write_en,
    input  logic [ADDR_WIDTH-1:0]      i_write_addr,
    input  logic [SPAD_DATA_WIDTH-1:0] i_write_data,
    input  logic                       i_read_en,
    input  logic [ADDR_WIDTH-1:0]      i_read_addr,
    output logic [SPAD_DATA_WIDTH-1:0] o_read_data
);

    logic [SPAD_DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // NOTE: the storage array has no reset so it can map onto RAM macros; its contents
    // are only meaningful after host writes, and the read register is qualified downstream.
    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_write_en) begin
            mem[i_write_addr] <= i_write_data;
        end
        if (i_read_en) begin
            o_read_data <= mem[i_read_addr];
        end
    end

endmodule

// File: rtl/weight_lane_buffer.sv
// One lane's private weight store: row-wide writes, single-weight reads at a shared index.
module weight_lane_buffer
    import router_pkg::*;
#(
    parameter int   SPAD_DATA_WIDTH = 64,
    parameter int   DATA_WIDTH      = 8,
    parameter int   DEPTH           = 32,
    localparam int  ELEMS           = elems_of(SPAD_DATA_WIDTH, DATA_WIDTH),
    localparam int  ROW_W           = row_idx_w(DEPTH, ELEMS),
    localparam int  IDX_W           = elem_idx_w(DEPTH)
) (
    input  logic                       i_clk,
    input  logic                       i_nrst,
    input  logic                       i_clear,
    input  logic                       i_write_en,
    input  logic [ROW_W-1:0]           i_write_row,
    input  logic [SPAD_DATA_WIDTH-1:0] i_write_data,
    input  logic [IDX_W-1:0]           i_read_idx,
    output logic [DATA_WIDTH-1:0]      o_read_data
);

    localparam int ROWS = DEPTH / ELEMS;
    localparam int EL_W = elem_idx_w(ELEMS);

    // Byte e of a written row lands at packed index e, i.e. weight row*ELEMS+e.
    logic [ELEMS-1:0][DATA_WIDTH-1:0] rows_q [ROWS];
    logic [ROW_W-1:0]                 rd_row;
    logic [EL_W-1:0]                  rd_elem;

    assign rd_row      = ROW_W'(i_read_idx / IDX_W'(ELEMS));
    assign rd_elem     = EL_W'(i_read_idx % IDX_W'(ELEMS));
    assign o_read_data = rows_q[rd_row][rd_elem];

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            for (int r = 0; r < ROWS; r++) rows_q[r] <= '0;
        end else if (i_clear) begin
            for (int r = 0; r < ROWS; r++) rows_q[r] <= '0;
        end else if (i_write_en) begin
            rows_q[i_write_row] <= i_write_data;
        end
    end

endmodule

// File: rtl/multi_lane_weight_router.sv
// Loads NUM_LANES weight regions from the scratchpad, then streams them in lockstep.
// Define WEIGHT_ROUTER_AUTO_REUSE_EN to repeat each pass i_reuse_count extra times.
module multi_lane_weight_router
    import router_pkg::*;
#(
    parameter int SPAD_DATA_WIDTH = 64,
    parameter int ADDR_WIDTH      = 8,
    parameter int DATA_WIDTH      = 8,
    parameter int NUM_LANES       = 4,
    parameter int DEPTH           = 32
) (
    input  logic                            i_clk,
    input  logic                            i_nrst,
    input  logic                            i_reg_clear,
    input  logic                            i_spad_write_en,
    input  logic [ADDR_WIDTH-1:0]           i_write_addr,
    input  logic [SPAD_DATA_WIDTH-1:0]      i_data_in,
    input  logic                            i_start,
    input  logic [ADDR_WIDTH-1:0]           i_start_addr,
    input  logic [ADDR_WIDTH-1:0]           i_lane_stride,
    input  logic [ADDR_WIDTH-1:0]           i_row_count,
    input  logic [ADDR_WIDTH-1:0]           i_route_size,
    input  logic [ADDR_WIDTH-1:0]           i_reuse_count,
    input  logic                            i_pop_en,
    input  logic                            i_reuse_en,
    output logic                            o_ready,
    output logic                            o_done,
    output logic [NUM_LANES*DATA_WIDTH-1:0] o_data,
    output logic                            o_data_valid
);

    localparam int ELEMS  = elems_of(SPAD_DATA_WIDTH, DATA_WIDTH);
    localparam int ROWS   = DEPTH / ELEMS;
    localparam int ROW_W  = row_idx_w(DEPTH, ELEMS);
    localparam int IDX_W  = elem_idx_w(DEPTH);
    localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    state_t                 state;
    logic [ADDR_WIDTH-1:0]  cfg_start_addr;
    logic [ADDR_WIDTH-1:0]  cfg_stride;
    logic [ROW_W-1:0]       cfg_last_row;
    logic [IDX_W-1:0]       cfg_last_idx;

    logic [LANE_W-1:0]      f_lane;
    logic [ROW_W-1:0]       f_row;
    logic [ADDR_WIDTH-1:0]  f_lane_base;
    logic                   f_issued;

    logic                   wr_pending;
    logic [LANE_W-1:0]      wr_lane;
    logic [ROW_W-1:0]       wr_row;

    logic [IDX_W-1:0]       rd_ptr;
    logic [SPAD_DATA_WIDTH-1:0] spad_rd_data;
    logic [ADDR_WIDTH-1:0]  spad_rd_addr;
    logic [NUM_LANES-1:0][DATA_WIDTH-1:0] lane_rd;

    int                     rows_req;
    int                     route_req;
    logic                   start_empty;
    logic [ROW_W-1:0]       start_last_row;
    logic [IDX_W-1:0]       start_last_idx;

    logic start_accept;
    logic buf_clear;
    logic fetch_issue;
    logic last_row;
    logic last_lane;
    logic pass_end_pop;
    logic auto_rewind;

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        rows_req       = (int'(i_row_count) > ROWS) ? ROWS : int'(i_row_count);
        route_req      = (int'(i_route_size) > DEPTH) ? DEPTH : int'(i_route_size);
        start_empty    = (rows_req == 0) || (route_req == 0);
        start_last_row = ROW_W'(rows_req - 1);
        start_last_idx = IDX_W'(route_req - 1);
    end

    assign start_accept = (state == ST_IDLE) && i_start;
    assign buf_clear    = i_reg_clear || start_accept;
    assign fetch_issue  = (state == ST_FETCH) && !f_issued && !i_reg_clear;
    assign spad_rd_addr = cfg_start_addr + f_lane_base + ADDR_WIDTH'(f_row);
    assign last_row     = (f_row == cfg_last_row);
    assign last_lane    = (f_lane == LANE_W'(NUM_LANES - 1));
    assign pass_end_pop = (state == ST_STREAM) && !i_reuse_en && i_pop_en
                          && (rd_ptr == cfg_last_idx);

`ifdef WEIGHT_ROUTER_AUTO_REUSE_EN
    logic [ADDR_WIDTH-1:0] pass_cnt;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            pass_cnt <= '0;
        end else if (i_reg_clear) begin
            pass_cnt <= '0;
        end else if (start_accept) begin
            pass_cnt <= i_reuse_count;
        end else if (pass_end_pop && (pass_cnt != '0)) begin
            pass_cnt <= pass_cnt - ADDR_WIDTH'(1);
        end
    end

    assign auto_rewind = (pass_cnt != '0);
`else
    logic unused_reuse_count;
    assign unused_reuse_count = ^i_reuse_count;
    assign auto_rewind        = 1'b0;
`endif

    spad #(
        .SPAD_DATA_WIDTH (SPAD_DATA_WIDTH),
        .ADDR_WIDTH      (ADDR_WIDTH)
    ) u_spad (
        .i_clk        (i_clk),
        .i_write_en   (i_spad_write_en),
        .i_write_addr (i_write_addr),
        .i_write_data (i_data_in),
        .i_read_en    (fetch_issue),
        .i_read_addr  (spad_rd_addr),
        .o_read_data  (spad_rd_data)
    );

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        weight_lane_buffer #(
            .SPAD_DATA_WIDTH (SPAD_DATA_WIDTH),
            .DATA_WIDTH      (DATA_WIDTH),
            .DEPTH           (DEPTH)
        ) u_buf (
            .i_clk        (i_clk),
            .i_nrst       (i_nrst),
            .i_clear      (buf_clear),
            .i_write_en   (wr_pending && (wr_lane == LANE_W'(k))),
            .i_write_row  (wr_row),
            .i_write_data (spad_rd_data),
            .i_read_idx   (rd_ptr),
            .o_read_data  (lane_rd[k])
        );
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state          <= ST_IDLE;
            cfg_start_addr <= '0;
            cfg_stride     <= '0;
            cfg_last_row   <= '0;
            cfg_last_idx   <= '0;
            f_lane         <= '0;
            f_row          <= '0;
            f_lane_base    <= '0;
            f_issued       <= 1'b0;
            wr_pending     <= 1'b0;
            wr_lane        <= '0;
            wr_row         <= '0;
            rd_ptr         <= '0;
            o_ready        <= 1'b0;
            o_done         <= 1'b0;
            o_data         <= '0;
            o_data_valid   <= 1'b0;
        end else if (i_reg_clear) begin
            state          <= ST_IDLE;
            cfg_start_addr <= '0;
            cfg_stride     <= '0;
            cfg_last_row   <= '0;
            cfg_last_idx   <= '0;
            f_lane         <= '0;
            f_row          <= '0;
            f_lane_base    <= '0;
            f_issued       <= 1'b0;
            wr_pending     <= 1'b0;
            wr_lane        <= '0;
            wr_row         <= '0;
            rd_ptr         <= '0;
            o_ready        <= 1'b0;
            o_done         <= 1'b0;
            o_data         <= '0;
            o_data_valid   <= 1'b0;
        end else begin
            o_data_valid <= 1'b0;
            // Returned row follows its read by one cycle, matching scratchpad latency.
            wr_pending   <= fetch_issue;
            wr_lane      <= f_lane;
            wr_row       <= f_row;

            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        cfg_start_addr <= i_start_addr;
                        cfg_stride     <= i_lane_stride;
                        cfg_last_row   <= start_last_row;
                        cfg_last_idx   <= start_last_idx;
                        f_lane         <= '0;
                        f_row          <= '0;
                        f_lane_base    <= '0;
                        f_issued       <= 1'b0;
                        rd_ptr         <= '0;
                        o_done         <= start_empty;
                        state          <= start_empty ? ST_DONE : ST_FETCH;
                    end
                end

                ST_FETCH: begin
                    if (!f_issued) begin
                        if (last_row) begin
                            f_row       <= '0;
                            f_lane      <= f_lane + LANE_W'(1);
                            f_lane_base <= f_lane_base + cfg_stride;
                            f_issued    <= last_lane;
                        end else begin
                            f_row <= f_row + ROW_W'(1);
                        end
                    end else begin
                        state   <= ST_STREAM;
                        o_ready <= 1'b1;
                    end
                end

                ST_STREAM: begin
                    if (i_reuse_en) begin
                        rd_ptr <= '0;
                    end else if (i_pop_en) begin
                        o_data       <= lane_rd;
                        o_data_valid <= 1'b1;
                        if (pass_end_pop) begin
                            rd_ptr <= '0;
                            if (!auto_rewind) begin
                                state   <= ST_DONE;
                                o_ready <= 1'b0;
                                o_done  <= 1'b1;
                            end
                        end else begin
                            rd_ptr <= rd_ptr + IDX_W'(1);
                        end
                    end
                end

                ST_DONE: begin
                    if (i_reuse_en) begin
                        rd_ptr  <= '0;
                        state   <= ST_STREAM;
                        o_ready <= 1'b1;
                        o_done  <= 1'b0;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/multi_lane_weight_router.md
# multi_lane_weight_router

Parametrised successor to the single-stream weight router. It feeds NUM_LANES PE columns in parallel from one weight scratchpad. A load FSM copies each lane's weight region from the scratchpad into a private lane buffer. All lanes then stream one weight per pop in lockstep, with kernel reuse through read-pointer rewind. The block sits between the weight SPAD write path (host/DMA) and the systolic array's weight inputs.

## Interface
- SPAD_DATA_WIDTH, 64: scratchpad row width; must be a multiple of DATA_WIDTH
- ADDR_WIDTH, 8: scratchpad address width
- DATA_WIDTH, 8: weight width; ELEMS = SPAD_DATA_WIDTH/DATA_WIDTH
- NUM_LANES, 4: parallel output lanes
- DEPTH, 32: weights per lane buffer; must be a multiple of ELEMS
- i_clk  in  1  clock
- i_nrst  in  1  asynchronous active-low reset
- i_reg_clear  in  1  synchronous clear of FSM, counters, buffers, outputs
- i_spad_write_en  in  1  scratchpad write strobe
- i_write_addr  in  ADDR_WIDTH  scratchpad write address
- i_data_in  in  SPAD_DATA_WIDTH  scratchpad write data
- i_start  in  1  begin load; honoured in IDLE only
- i_start_addr  in  ADDR_WIDTH  first row of lane 0
- i_lane_stride  in  ADDR_WIDTH  row distance between consecutive lanes' regions
- i_row_count  in  ADDR_WIDTH  rows per lane; clamped to DEPTH/ELEMS
- i_route_size  in  ADDR_WIDTH  weights per pass; clamped to DEPTH
- i_reuse_count  in  ADDR_WIDTH  extra passes (used only with the macro below)
- i_pop_en  in  1  pop one weight from every lane
- i_reuse_en  in  1  rewind read pointer, start a new pass
- o_ready  out  1  high in STREAM
- o_done  out  1  high in DONE
- o_data  out  NUM_LANES*DATA_WIDTH  lane k at bits [k*DATA_WIDTH +: DATA_WIDTH]
- o_data_valid  out  1  o_data valid this cycle

## Operation
- FSM states: IDLE, FETCH, STREAM, DONE. Reset and i_reg_clear force IDLE.
- IDLE -> FETCH on i_start. At i_start, all lane buffers are zeroed and the read pointer is set to 0.
  - If i_row_count==0 or i_route_size==0, go IDLE -> DONE instead. No scratchpad reads are issued.
- Configuration inputs are sampled at i_start and held internally. Later changes to the inputs have no effect until the next start.
- FETCH: issue one scratchpad read per cycle, lane-major.
  - Order: lane 0 rows 0..R-1, then lane 1, and so on.
  - Read address = i_start_addr + lane*i_lane_stride + row, modulo 2^ADDR_WIDTH (wraps silently).
- Returned row (1-cycle SPAD latency) is written to the lane's buffer at row slot `row`. Byte e of the row becomes weight index row*ELEMS+e.
- FETCH -> STREAM once the last read's data is written: NUM_LANES*R + 1 cycles after entering FETCH.
- STREAM: each accepted pop outputs weight[rd_ptr] of every lane, then rd_ptr++. Weights never loaded read as 0.
- When the pop with rd_ptr == route_size-1 is accepted, the pass ends (see Configuration).
- DONE: pops are ignored. i_reuse_en -> STREAM with rd_ptr=0 and o_done cleared.
- i_reuse_en in STREAM rewinds rd_ptr to 0 and has priority over a simultaneous pop; that pop is dropped.
- i_reuse_en in IDLE or FETCH is ignored. i_pop_en outside STREAM is ignored.
- i_reg_clear has priority over every other input.
- Scratchpad writes are accepted in every state. A write to a row during FETCH has undefined data ordering; software must avoid it.

## Timing
- Reset values: o_ready=0, o_done=0, o_data=0, o_data_valid=0, state IDLE, all buffers 0.
- Pop latency: o_data/o_data_valid are registered, so they appear 1 cycle after the accepting i_pop_en. o_data_valid lasts one cycle per pop; o_data holds its value between pops.
- Back-to-back pops: one weight per cycle with no bubbles, including across an automatic rewind.
- o_ready rises in the first STREAM cycle. o_done rises the cycle after the last pop is accepted.
- Reset asserted mid-FETCH or mid-STREAM: all state clears immediately. No partial output follows.

## Configuration
- WEIGHT_ROUTER_AUTO_REUSE_EN defined:
  - A pass-counter loads i_reuse_count at i_start.
  - At end of pass with counter>0: decrement, rewind rd_ptr to 0 in the same cycle, stay in STREAM.
  - With counter==0: go to DONE.
- Undefined: end of pass always goes to DONE. Further passes need i_reuse_en, and i_reuse_count is ignored.

## Structure
- router_pkg holds:
  - the state enum (IDLE/FETCH/STREAM/DONE)
  - the ELEMS localparam function
  - the lane-buffer row/element index widths ($clog2 of DEPTH/ELEMS and of DEPTH)
- Reuse existing `spad` for weight storage.
- One sub-module, weight_lane_buffer: DEPTH×DATA_WIDTH storage with a row-wide write, a synchronous clear and a byte read at a shared index. Instantiate it NUM_LANES times in a generate loop.

## Test plan
- NUM_LANES=4, R=2, stride=4, start=0; rows hold byte=addr*8+e; route_size=16, 16 back-to-back pops → lane k emits (4k*8)..(4k*8+15) in order; o_ready after 9 FETCH cycles; o_done after the 16th pop.
- route_size=20 with R=2 → pops 17..20 return 0 on all lanes.
- Macro defined, i_reuse_count=2, route_size=9 → 27 consecutive valid outputs, sequence 0..8 three times with no gap; then o_done.
- Macro undefined; DONE, then i_reuse_en, then 9 pops → sequence repeats. Same-cycle i_reuse_en+i_pop_en mid-pass → pop dropped, next output is index 0.
- start_addr=0xFE, stride=1, R=2 → lane 0 reads 0xFE,0xFF; lane 1 reads 0xFF,0x00 (wrap).
- i_nrst pulsed mid-FETCH, and separately i_reg_clear mid-STREAM → all outputs 0 next edge, state IDLE; fresh i_start reloads correctly.
